// File: rtl/apb_arb_pkg.sv
// Shared definitions for the APB arbiter: FSM state encoding, peripheral
// port codes and the data word returned on an ACCESS timeout.
package apb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } arb_state_e;

  localparam logic [2:0] PORT_GPIO  = 3'b010;
  localparam logic [2:0] PORT_UART  = 3'b011;
  localparam logic [2:0] PORT_SPI   = 3'b100;
  localparam logic [2:0] PORT_I2C   = 3'b101;
  localparam logic [2:0] PORT_TIMER = 3'b110;
  localparam logic [2:0] PORT_PWM   = 3'b111;

  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/rr_pick.sv
// Round-robin winner selection, purely combinational.
// Ports:
//   req        - per-requester request vector
//   last_owner - index of the most recent owner; search starts one above it
//   winner     - one-hot winning requester (0 when no request)
//   valid      - at least one request is pending
module rr_pick #(
  parameter int NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last_owner,
  output logic [NUM_REQ-1:0]         winner,
  output logic                       valid
);

  localparam int IDX_W = $clog2(NUM_REQ);

  always_comb begin
    logic [IDX_W-1:0] pos;
    winner = '0;
    valid  = 1'b0;
    pos    = '0;
    // Walk the requesters in rotated order; the first hit wins.
    for (int k = 1; k <= NUM_REQ; k++) begin
      pos = IDX_W'((int'(last_owner) + k) % NUM_REQ);
      if (!valid && req[pos]) begin
        winner[pos] = 1'b1;
        valid       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_arbiter.sv
// Round-robin arbiter granting one of NUM_REQ requesters access to a single
// APB slave, with a four-state transfer FSM.
// Optional feature: define APB_ARB_TIMEOUT_EN to bound the ACCESS phase to
// TIMEOUT_CYC cycles; a timed-out transfer completes with err=1 and
// rdata=TIMEOUT_DATA.
// Ports:
//   clk, rst                         - clock, synchronous active-high reset
//   req, wr, sel_port, addr, wdata   - packed per-requester transfer requests
//   gnt, done, rdata, err            - per-requester grant/completion, read data
//   m_en, m_wr, m_sel_port, m_addr,
//   m_wdata, m_ready, m_rdata        - slave-side transfer interface
//
// state  | meaning
// IDLE   | no transfer; pick a winner and latch its request fields
// SETUP  | first enabled cycle towards the slave
// ACCESS | enabled, waiting for m_ready (or timeout)
// DONE   | done pulse to owner, rdata valid; rotate priority
module apb_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NUM_REQ     = 3,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ-1:0]    wr,
  input  logic [3*NUM_REQ-1:0]  sel_port,
  input  logic [12*NUM_REQ-1:0] addr,
  input  logic [32*NUM_REQ-1:0] wdata,
  output logic [NUM_REQ-1:0]    gnt,
  output logic [NUM_REQ-1:0]    done,
  output logic [31:0]           rdata,
  output logic                  err,
  output logic                  m_en,
  output logic                  m_wr,
  output logic [2:0]            m_sel_port,
  output logic [11:0]           m_addr,
  output logic [31:0]           m_wdata,
  input  logic                  m_ready,
  input  logic [31:0]           m_rdata
);

  localparam int IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 4) begin : g_bad_num_req
    $error("apb_arbiter: NUM_REQ must be 2..4");
  end
  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_timeout
    $error("apb_arbiter: TIMEOUT_CYC must be 1..255");
  end

  arb_state_e         state, state_nxt;
  logic [NUM_REQ-1:0] winner;
  logic               win_valid;
  logic [IDX_W-1:0]   last_owner, owner_idx;
  logic               timeout_hit;

  logic               pick_wr;
  logic [2:0]         pick_sel;
  logic [11:0]        pick_addr;
  logic [31:0]        pick_wdata;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
    .req        (req),
    .last_owner (last_owner),
    .winner     (winner),
    .valid      (win_valid)
  );

  // Request fields of the current round-robin winner.
  always_comb begin
    pick_wr    = 1'b0;
    pick_sel   = '0;
    pick_addr  = '0;
    pick_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner[i]) begin
        pick_wr    = wr[i];
        pick_sel   = sel_port[3*i +: 3];
        pick_addr  = addr[12*i +: 12];
        pick_wdata = wdata[32*i +: 32];
      end
    end
  end

  always_comb begin
    owner_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) owner_idx = IDX_W'(i);
    end
  end

`ifdef APB_ARB_TIMEOUT_EN
  logic [7:0] tmo_cnt;
  logic       err_q;

  // tmo_cnt holds the number of ACCESS cycles already completed, so the
  // limit is reached in the TIMEOUT_CYC-th ACCESS cycle.
  assign timeout_hit = (state == ACCESS) && !m_ready &&
                       (tmo_cnt == 8'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= timeout_hit;
      if (state == ACCESS) tmo_cnt <= tmo_cnt + 8'd1;
      else                 tmo_cnt <= '0;
    end
  end

  assign err = err_q;
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_valid) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (m_ready || timeout_hit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt        <= '0;
      last_owner <= IDX_W'(NUM_REQ - 1);
      rdata      <= '0;
      m_wr       <= 1'b0;
      m_sel_port <= '0;
      m_addr     <= '0;
      m_wdata    <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Fields are captured once here so later changes on the owner's
          // inputs cannot disturb the bus during the transfer.
          if (win_valid) begin
            gnt        <= winner;
            m_wr       <= pick_wr;
            m_sel_port <= pick_sel;
            m_addr     <= pick_addr;
            m_wdata    <= pick_wdata;
          end
        end
        ACCESS: begin
          if (m_ready)          rdata <= m_rdata;
          else if (timeout_hit) rdata <= TIMEOUT_DATA;
        end
        DONE: begin
          last_owner <= owner_idx;
          gnt        <= '0;
        end
        default: ;
      endcase
    end
  end

  assign m_en = (state == SETUP) || (state == ACCESS);
  assign done = gnt & {NUM_REQ{state == DONE}};

endmodule

// File: tb/tb_apb_arbiter.sv
module tb_apb_arbiter;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int TCYC = 8;
`else
  localparam int TCYC = 255;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req;
  logic [2:0]  wr;
  logic [8:0]  sel_port;
  logic [35:0] addr;
  logic [95:0] wdata;
  logic [2:0]  gnt, done;
  logic [31:0] rdata;
  logic        err;
  logic        m_en, m_wr;
  logic [2:0]  m_sel_port;
  logic [11:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_ready;
  logic [31:0] m_rdata;

  logic        f_wr[3];
  logic [2:0]  f_sel[3];
  logic [11:0] f_addr[3];
  logic [31:0] f_wdata[3];

  int checks = 0;
  int failures = 0;
  int model_last;

  assign wr       = {f_wr[2], f_wr[1], f_wr[0]};
  assign sel_port = {f_sel[2], f_sel[1], f_sel[0]};
  assign addr     = {f_addr[2], f_addr[1], f_addr[0]};
  assign wdata    = {f_wdata[2], f_wdata[1], f_wdata[0]};

  always #5 clk = ~clk;

  apb_arbiter #(.NUM_REQ(3), .TIMEOUT_CYC(TCYC)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .wr         (wr),
    .sel_port   (sel_port),
    .addr       (addr),
    .wdata      (wdata),
    .gnt        (gnt),
    .done       (done),
    .rdata      (rdata),
    .err        (err),
    .m_en       (m_en),
    .m_wr       (m_wr),
    .m_sel_port (m_sel_port),
    .m_addr     (m_addr),
    .m_wdata    (m_wdata),
    .m_ready    (m_ready),
    .m_rdata    (m_rdata)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Round-robin rule: first requester at or after (last+1) mod 3.
  function automatic int pick(input logic [2:0] rq, input int last);
    for (int k = 1; k <= 3; k++) begin
      int i;
      i = (last + k) % 3;
      if (rq[i]) return i;
    end
    return 0;
  endfunction

  task automatic randomize_fields();
    for (int i = 0; i < 3; i++) begin
      f_wr[i]    = 1'($urandom);
      f_sel[i]   = 3'($urandom);
      f_addr[i]  = 12'($urandom);
      f_wdata[i] = $urandom;
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of the
  // idle cycle that follows the transfer.
  task automatic run_xfer(input logic [2:0] rq, input int lat, input bit hold_all,
                          input logic [31:0] rd);
    int w;
    logic [2:0] eg;
    logic ew;
    logic [2:0] es;
    logic [11:0] ea;
    logic [31:0] ed;
    req = rq;
    w  = pick(rq, model_last);
    eg = 3'(1 << w);
    ew = f_wr[w];
    es = f_sel[w];
    ea = f_addr[w];
    ed = f_wdata[w];
    @(negedge clk);
    chk("setup", {gnt, done, m_en, m_wr, m_sel_port, m_addr, m_wdata},
                 {eg, 3'b000, 1'b1, ew, es, ea, ed});
    if (!hold_all) begin
      req[w]     = 1'b0;
      f_wr[w]    = ~f_wr[w];
      f_sel[w]   = f_sel[w] + 3'd1;
      f_addr[w]  = ~f_addr[w];
      f_wdata[w] = ~f_wdata[w];
    end
    for (int i = 0; i <= lat; i++) begin
      @(negedge clk);
      chk("access", {gnt, done, m_en, m_wr, m_sel_port, m_addr, m_wdata},
                    {eg, 3'b000, 1'b1, ew, es, ea, ed});
    end
    m_ready = 1'b1;
    m_rdata = rd;
    @(negedge clk);
    chk("done", {gnt, done, m_en, err, rdata, m_wr, m_sel_port, m_addr, m_wdata},
                {eg, eg, 1'b0, 1'b0, rd, ew, es, ea, ed});
    m_ready = 1'b0;
    m_rdata = $urandom;
    model_last = w;
    @(negedge clk);
    chk("idle", {gnt, done, m_en, err}, '0);
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    m_ready = 1'b0;
    m_rdata = '0;
    model_last = 2;
    randomize_fields();
    repeat (2) @(negedge clk);
    chk("reset", {gnt, done, rdata, err, m_en, m_wr, m_sel_port, m_addr, m_wdata}, '0);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_idle", {gnt, done, m_en}, '0);

    // All requesters held: grants rotate 0,1,2.
    for (int n = 0; n < 3; n++) run_xfer(3'b111, 0, 1'b1, $urandom);

    // Single write from requester 0.
    f_wr[0] = 1'b1; f_sel[0] = 3'b011; f_addr[0] = 12'h004; f_wdata[0] = 32'hA5A5_0001;
    run_xfer(3'b001, 0, 1'b0, $urandom);

    // Read from requester 2 with a slow slave.
    randomize_fields();
    f_wr[2] = 1'b0;
    run_xfer(3'b100, 5, 1'b0, 32'h1234_5678);

    // Invalid port code forwarded untouched.
    f_sel[1] = 3'b000;
    run_xfer(3'b010, 1, 1'b0, $urandom);

    // Reset in the middle of ACCESS.
    randomize_fields();
    req = 3'b001;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    m_ready = 1'b1;
    @(negedge clk);
    chk("abort", {gnt, done, rdata, err, m_en, m_wr, m_sel_port, m_addr, m_wdata}, '0);
    rst = 1'b0;
    m_ready = 1'b0;
    model_last = 2;
    run_xfer(3'b110, 0, 1'b0, $urandom);

`ifdef APB_ARB_TIMEOUT_EN
    begin
      int w;
      randomize_fields();
      req = 3'b001;
      w = pick(3'b001, model_last);
      @(negedge clk);
      chk("tmo_setup", {gnt, m_en}, {3'(1 << w), 1'b1});
      req = '0;
      for (int i = 0; i < TCYC; i++) begin
        @(negedge clk);
        chk("tmo_access", {gnt, done, m_en, err}, {3'(1 << w), 3'b000, 1'b1, 1'b0});
      end
      @(negedge clk);
      chk("tmo_done", {done, err, rdata, m_en}, {3'(1 << w), 1'b1, 32'hDEAD_BEEF, 1'b0});
      model_last = w;
      @(negedge clk);
      chk("tmo_idle", {gnt, done, err, m_en}, '0);
    end
`endif

    // Randomized transfers against the round-robin model.
    for (int n = 0; n < 25; n++) begin
      randomize_fields();
      run_xfer(3'($urandom_range(1, 7)), $urandom_range(0, 4),
               1'($urandom_range(0, 1)), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
